// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver: FSM states,
// response codes and the bit-counter width helper.
package serial_frame_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] RSP_NONE = 2'b00;
    localparam logic [1:0] RSP_ACK  = 2'b01;
    localparam logic [1:0] RSP_NAK  = 2'b10;
    localparam logic [1:0] RSP_FRM  = 2'b11;

    localparam int DEFAULT_DATA_BITS = 8;

    // Counter must reach DATA_BITS itself, hence the +1.
    function automatic int cnt_width(input int data_bits);
        return $clog2(data_bits + 1);
    endfunction

endpackage

// File: rtl/serial_frame_shift.sv
// Payload shift register, bit counter and running even parity for one frame.
// The controlling FSM decides when a frame starts, shifts, or is cleared.
module serial_frame_shift
    import serial_frame_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int CW        = cnt_width(DEFAULT_DATA_BITS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 shift_en,
    input  logic                 clear,
    input  logic                 bit_in,
    output logic [DATA_BITS-1:0] data,
    output logic [CW-1:0]        cnt,
    output logic                 parity
);

    logic [DATA_BITS-1:0] data_q, data_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 parity_q, parity_d;

    // Start loads bit 0 directly so a frame can begin on any cycle,
    // including the one right after a previous frame's parity bit.
    always_comb begin
        data_d   = data_q;
        cnt_d    = cnt_q;
        parity_d = parity_q;
        if (clear) begin
            data_d   = '0;
            cnt_d    = '0;
            parity_d = 1'b0;
        end else if (start) begin
            data_d   = DATA_BITS'(bit_in);
            cnt_d    = CW'(1);
            parity_d = bit_in;
        end else if (shift_en) begin
            data_d   = data_q | (DATA_BITS'(bit_in) << cnt_q);
            cnt_d    = cnt_q + CW'(1);
            parity_d = parity_q ^ bit_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= '0;
            cnt_q    <= '0;
            parity_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            parity_q <= parity_d;
        end
    end

    assign data   = data_q;
    assign cnt    = cnt_q;
    assign parity = parity_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: strobed LSB-first payload plus even parity, with
// registered ack/nak/framing response, last-good-payload hold and error count.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int ERR_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           io_in,
    output logic [1:0]           io_out,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic [ERR_W-1:0]     err_cnt
);

    localparam int             CW       = cnt_width(DATA_BITS);
    localparam logic [CW-1:0]  LAST_CNT = CW'(DATA_BITS);

    state_t               state_q, state_d;
    logic [1:0]           rsp_q, rsp_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;

    logic                 sh_start, sh_shift_en, sh_clear, err_inc;
    logic [DATA_BITS-1:0] sh_data;
    logic [CW-1:0]        sh_cnt;
    logic                 sh_parity;

    logic                 strobe, bit_in;
    assign bit_in = io_in[0];
    assign strobe = io_in[1];

    serial_frame_shift #(
        .DATA_BITS (DATA_BITS),
        .CW        (CW)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .start    (sh_start),
        .shift_en (sh_shift_en),
        .clear    (sh_clear),
        .bit_in   (bit_in),
        .data     (sh_data),
        .cnt      (sh_cnt),
        .parity   (sh_parity)
    );

    // Completing or aborting a frame always returns to IDLE; a strobe in the
    // following cycle then starts the next frame with no gap.
    always_comb begin
        state_d     = state_q;
        rsp_d       = RSP_NONE;
        rx_valid_d  = 1'b0;
        rx_data_d   = rx_data_q;
        sh_start    = 1'b0;
        sh_shift_en = 1'b0;
        sh_clear    = 1'b0;
        err_inc     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (strobe) begin
                    sh_start = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (!strobe) begin
                    rsp_d    = RSP_FRM;
                    err_inc  = 1'b1;
                    sh_clear = 1'b1;
                    state_d  = IDLE;
                end else if (sh_cnt < LAST_CNT) begin
                    sh_shift_en = 1'b1;
                end else begin
                    if ((sh_parity ^ bit_in) == 1'b0) begin
                        rsp_d      = RSP_ACK;
                        rx_valid_d = 1'b1;
                        rx_data_d  = sh_data;
                    end else begin
                        rsp_d   = RSP_NAK;
                        err_inc = 1'b1;
                    end
                    sh_clear = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_inc && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rsp_q      <= RSP_NONE;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rsp_q      <= rsp_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign io_out   = rsp_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter DATA_BITS, default 8: payload bits per frame.
REQ-002 Parameter ERR_W, default 8: error counter width.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 io_in  input  2  io_in[0]=serial data (LSB first); io_in[1]=frame strobe (high = bit cycle).
REQ-006 io_out  output  2  response: io_out[0]=ack, io_out[1]=nak; 2'b11 = framing error.
REQ-007 rx_data  output  DATA_BITS  last good payload, held until the next good frame.
REQ-008 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-009 err_cnt  output  ERR_W  saturating count of parity plus framing errors.

Function
REQ-010 Frame format: DATA_BITS+1 consecutive cycles with io_in[1]=1.
REQ-011 Frame payload: DATA_BITS data bits, LSB first, then one even-parity bit.
REQ-012 States: IDLE and SHIFT, with a bit counter 0..DATA_BITS.
REQ-013 IDLE: io_in[1]=1 samples data bit 0, sets counter to 1, and moves to SHIFT.
REQ-014 IDLE: io_in[1]=0 holds the block in IDLE.
REQ-015 SHIFT with io_in[1]=1 and counter<DATA_BITS: shift io_in[0] into bit[counter], increment counter.
REQ-016 SHIFT with io_in[1]=1 and counter=DATA_BITS: sample the parity bit and complete the frame.
REQ-017 Good frame (XOR of data and parity = 0): io_out=2'b01, rx_valid=1, rx_data=payload, all visible the cycle after the parity cycle.
REQ-018 Bad parity: io_out=2'b10 the cycle after the parity cycle; rx_valid=0; rx_data unchanged; err_cnt increments.
REQ-019 Framing error (io_in[1]=0 while in SHIFT): io_out=2'b11 the following cycle; payload discarded; err_cnt increments; return to IDLE.
REQ-020 io_out, rx_valid and response pulses last exactly one cycle, then return to 0.
REQ-021 Back-to-back frames: if io_in[1] stays 1 in the cycle after parity, that cycle is bit 0 of the next frame; no idle gap is required.
REQ-022 During back-to-back frames, the response for the previous frame still appears in that cycle.
REQ-023 err_cnt saturates at 2^ERR_W-1 and never wraps.
REQ-024 Latency: last strobe cycle to response is exactly 1 cycle; every output is registered.

Reset
REQ-025 Reset sets: state=IDLE, counter=0, io_out=2'b00, rx_valid=0, rx_data=0, err_cnt=0.
REQ-026 Reset mid-frame discards the partial frame; no response pulse is emitted for it.
REQ-027 Reset has priority over every other event in the same cycle.
REQ-028 The first frame is accepted in the first cycle after reset deasserts with io_in[1]=1.

Structure
REQ-029 Package serial_frame_pkg holds: state enum (IDLE, SHIFT), response codes (RSP_NONE=00, RSP_ACK=01, RSP_NAK=10, RSP_FRM=11), default DATA_BITS.
REQ-030 Sub-module serial_frame_shift holds the shift register, bit counter and running parity.
REQ-031 serial_frame_shift is cleared by the top-level frame-start and abort signals.
REQ-032 The top level holds the FSM, response register and error counter.

Verification
REQ-033 Frame 0xA5, parity 0 -> io_out=01, rx_valid=1, rx_data=0xA5 one cycle after the parity cycle; err_cnt=0.
REQ-034 Frame 0x07, parity 0 -> io_out=10, rx_valid=0, rx_data holds its previous value, err_cnt=1.
REQ-035 Strobe dropped after 4 data bits -> io_out=11 the next cycle, state returns to IDLE, err_cnt increments.
REQ-036 Back-to-back 0x01 (parity 1) then 0xFF (parity 0) with no gap -> two ack pulses 9 cycles apart; rx_data=0x01, then 0xFF.
REQ-037 Reset asserted at bit 5 of a frame, then a clean 0x3C frame -> no response for the partial frame; ack for 0x3C; rx_data=0x3C.
REQ-038 260 consecutive bad-parity frames -> err_cnt stops at 255; io_out=10 on every frame.
